des_round_sequencer: RTL and testbench
======================================

DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1 bit, single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-003 SHALL have port START, input, 1 bit, request to begin one block operation.
REQ-004 SHALL have port MODE, input, 1 bit, 0 = encrypt, 1 = decrypt; sampled with START.
REQ-005 SHALL have port IN_READY, output, 1 bit, high when a START will be accepted.
REQ-006 SHALL have port LOAD, output, 1 bit, datapath captures a new block and PC-1 key.
REQ-007 SHALL have port RELOAD, output, 1 bit, datapath captures its own round output instead of the input block (3DES pass boundary).
REQ-008 SHALL have port ROUND_EN, output, 1 bit, datapath executes one Feistel round this cycle.
REQ-009 SHALL have port ROUND_NUM, output, 4 bits, current round index 0..15.
REQ-010 SHALL have port SHIFT_LEFT, output, 1 bit, key rotate direction: 1 = left (encrypt pass), 0 = right (decrypt pass).
REQ-011 SHALL have port SHIFT_AMT, output, 2 bits, key half rotate amount for the current round (0, 1 or 2).
REQ-012 SHALL have port LAST_ROUND, output, 1 bit, high with ROUND_NUM = 15; datapath omits the L/R swap.
REQ-013 SHALL have port KEY_SEL, output, 2 bits, selects key K1/K2/K3 (0/1/2).
REQ-014 SHALL have port OUT_VALID, output, 1 bit, result is held valid at datapath output.
REQ-015 SHALL have port OUT_READY, input, 1 bit, consumer accepts the result.

Function
REQ-016 SHALL implement states IDLE, LOAD, ROUND, HOLD; all outputs registered or decoded from registered state only.
REQ-017 IDLE: IN_READY = 1; START = 1 at an edge latches MODE and moves to LOAD.
REQ-018 LOAD: one cycle, LOAD = 1 (or RELOAD = 1 on later passes), then ROUND with ROUND_NUM = 0.
REQ-019 ROUND: 16 cycles, ROUND_EN = 1, ROUND_NUM increments 0..15; after ROUND_NUM = 15, go to HOLD (or LOAD for the next pass).
REQ-020 Encrypt-pass SHIFT_AMT per round 0..15 SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with SHIFT_LEFT = 1.
REQ-021 Decrypt-pass SHIFT_AMT per round 0..15 SHALL be 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with SHIFT_LEFT = 0.
REQ-022 SHIFT_AMT SHALL be 0 and SHIFT_LEFT SHALL be 0 whenever ROUND_EN = 0.
REQ-023 HOLD: OUT_VALID = 1 until OUT_READY = 1 at an edge, then IDLE; OUT_VALID SHALL NOT drop without OUT_READY.
REQ-024 Single-DES latency SHALL be 18 cycles from the START-accept edge to OUT_VALID rising (1 LOAD + 16 ROUND + 1).
REQ-025 START while IN_READY = 0 SHALL be ignored and not queued; MODE changes after acceptance SHALL have no effect.
REQ-026 OUT_READY while OUT_VALID = 0 SHALL be ignored.
REQ-027 IN_READY SHALL be 0 in every state except IDLE, including the cycle OUT_VALID/OUT_READY completes.

Reset
REQ-028 RST high SHALL immediately force IDLE regardless of state or pass, aborting any operation in progress.
REQ-029 Reset values: IN_READY = 1; LOAD, RELOAD, ROUND_EN, LAST_ROUND, OUT_VALID = 0; ROUND_NUM, SHIFT_AMT, KEY_SEL = 0; SHIFT_LEFT = 0.
REQ-030 First START SHALL be acceptable on the first rising edge after RST deasserts.

Configuration
REQ-031 Macro DES_TRIPLE_EN defined: three passes per block (EDE); encrypt = E(K1), D(K2), E(K3); decrypt = D(K3), E(K2), D(K1).
REQ-032 With DES_TRIPLE_EN: KEY_SEL follows the pass key; passes 2 and 3 start with a RELOAD cycle; latency = 52 cycles.
REQ-033 Without DES_TRIPLE_EN: single pass, KEY_SEL = 0, RELOAD = 0 constantly, latency 18; port list identical in both builds.

Verification
REQ-034 Reset, START = 1, MODE = 0, OUT_READY = 1 -> LOAD at cycle 1, ROUND_NUM 0..15 at cycles 2..17, OUT_VALID at 18, IN_READY at 19.
REQ-035 MODE = 1 run -> SHIFT_LEFT = 0, SHIFT_AMT sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, LAST_ROUND only at ROUND_NUM = 15.
REQ-036 OUT_READY held 0 for 10 cycles after OUT_VALID -> OUT_VALID stays 1, extra START ignored, IDLE one cycle after OUT_READY = 1.
REQ-037 RST pulsed at ROUND_NUM = 7 -> all outputs at reset values asynchronously; new START then gives 18-cycle latency.
REQ-038 DES_TRIPLE_EN, MODE = 0 -> KEY_SEL 0,1,2, SHIFT_LEFT 1,0,1 per pass, RELOAD at cycles 18 and 35, OUT_VALID at 52.

Source files
------------

// File: rtl/des_round_sequencer.sv
// DES round sequencer: steps a Feistel datapath through LOAD, 16 rounds and
// a result hold, driving key-schedule rotate controls for each round.
// Build option: define DES_TRIPLE_EN for three-pass EDE (3DES) sequencing;
// without it a single DES pass is run and KEY_SEL/RELOAD stay at zero.
module des_round_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       MODE,
  output logic       IN_READY,
  output logic       LOAD,
  output logic       RELOAD,
  output logic       ROUND_EN,
  output logic [3:0] ROUND_NUM,
  output logic       SHIFT_LEFT,
  output logic [1:0] SHIFT_AMT,
  output logic       LAST_ROUND,
  output logic [1:0] KEY_SEL,
  output logic       OUT_VALID,
  input  logic       OUT_READY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

`ifdef DES_TRIPLE_EN
  localparam logic [1:0] LAST_PASS = 2'd2;
`else
  localparam logic [1:0] LAST_PASS = 2'd0;
`endif

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] pass_q, pass_d;
  logic       mode_q, mode_d;

  logic       in_ready_q, in_ready_d;
  logic       load_q, load_d;
  logic       reload_q, reload_d;
  logic       round_en_q, round_en_d;
  logic [3:0] round_num_q, round_num_d;
  logic       shift_left_q, shift_left_d;
  logic [1:0] shift_amt_q, shift_amt_d;
  logic       last_round_q, last_round_d;
  logic [1:0] key_sel_q, key_sel_d;
  logic       out_valid_q, out_valid_d;
  logic       decrypt_pass;

  // Key-half rotate amount per round; a decrypt pass rotates right and skips
  // the first rotation so round 0 uses the unrotated PC-1 halves.
  function automatic logic [1:0] shift_amount(input logic [3:0] rnd,
                                               input logic       dec);
    logic [1:0] amt;
    amt = 2'd2;
    if (rnd == 4'd0) begin
      amt = dec ? 2'd0 : 2'd1;
    end else if (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) begin
      amt = 2'd1;
    end
    return amt;
  endfunction

  // Next-state: sequence IDLE -> LOAD -> 16x ROUND -> (LOAD for next pass | HOLD).
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    pass_d  = pass_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mode_d  = MODE;
          pass_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        round_d = '0;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (round_q == 4'd15) begin
          round_d = '0;
          if (pass_q != LAST_PASS) begin
            pass_d  = pass_q + 2'd1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every port comes straight off a flop.
  // EDE: middle pass runs opposite direction to the requested mode.
  always_comb begin
    decrypt_pass = mode_d ^ (pass_d == 2'd1);
    in_ready_d   = (state_d == ST_IDLE);
    load_d       = (state_d == ST_LOAD) && (pass_d == 2'd0);
    reload_d     = (state_d == ST_LOAD) && (pass_d != 2'd0);
    round_en_d   = (state_d == ST_ROUND);
    round_num_d  = round_en_d ? round_d : 4'd0;
    last_round_d = round_en_d && (round_d == 4'd15);
    shift_left_d = round_en_d && !decrypt_pass;
    shift_amt_d  = round_en_d ? shift_amount(round_d, decrypt_pass) : 2'd0;
    out_valid_d  = (state_d == ST_HOLD);
`ifdef DES_TRIPLE_EN
    if ((state_d == ST_LOAD) || (state_d == ST_ROUND)) begin
      key_sel_d = mode_d ? (2'd2 - pass_d) : pass_d;
    end else begin
      key_sel_d = '0;
    end
`else
    key_sel_d = '0;
`endif
  end

  // State and registered outputs; reset aborts any operation in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      round_q      <= '0;
      pass_q       <= '0;
      mode_q       <= 1'b0;
      in_ready_q   <= 1'b1;
      load_q       <= 1'b0;
      reload_q     <= 1'b0;
      round_en_q   <= 1'b0;
      round_num_q  <= '0;
      shift_left_q <= 1'b0;
      shift_amt_q  <= '0;
      last_round_q <= 1'b0;
      key_sel_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      pass_q       <= pass_d;
      mode_q       <= mode_d;
      in_ready_q   <= in_ready_d;
      load_q       <= load_d;
      reload_q     <= reload_d;
      round_en_q   <= round_en_d;
      round_num_q  <= round_num_d;
      shift_left_q <= shift_left_d;
      shift_amt_q  <= shift_amt_d;
      last_round_q <= last_round_d;
      key_sel_q    <= key_sel_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign IN_READY   = in_ready_q;
  assign LOAD       = load_q;
  assign RELOAD     = reload_q;
  assign ROUND_EN   = round_en_q;
  assign ROUND_NUM  = round_num_q;
  assign SHIFT_LEFT = shift_left_q;
  assign SHIFT_AMT  = shift_amt_q;
  assign LAST_ROUND = last_round_q;
  assign KEY_SEL    = key_sel_q;
  assign OUT_VALID  = out_valid_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer: cycle-exact output vectors for
// encrypt/decrypt blocks, back-pressure on the result, and mid-round reset.
module tb_des_round_sequencer;

  logic       CLK, RST, START, MODE, OUT_READY;
  logic       IN_READY, LOAD, RELOAD, ROUND_EN, SHIFT_LEFT, LAST_ROUND, OUT_VALID;
  logic [3:0] ROUND_NUM;
  logic [1:0] SHIFT_AMT, KEY_SEL;

`ifdef DES_TRIPLE_EN
  localparam int unsigned NPASS = 3;
`else
  localparam int unsigned NPASS = 1;
`endif

  localparam int unsigned ENC_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int unsigned DEC_SH [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  // {IN_READY,LOAD,RELOAD,ROUND_EN,ROUND_NUM,SHIFT_LEFT,SHIFT_AMT,LAST_ROUND,KEY_SEL,OUT_VALID}
  localparam logic [14:0] IDLE_VEC = 15'h4000;
  localparam logic [14:0] HOLD_VEC = 15'h0001;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  des_round_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .MODE       (MODE),
    .IN_READY   (IN_READY),
    .LOAD       (LOAD),
    .RELOAD     (RELOAD),
    .ROUND_EN   (ROUND_EN),
    .ROUND_NUM  (ROUND_NUM),
    .SHIFT_LEFT (SHIFT_LEFT),
    .SHIFT_AMT  (SHIFT_AMT),
    .LAST_ROUND (LAST_ROUND),
    .KEY_SEL    (KEY_SEL),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [14:0] obs();
    return {IN_READY, LOAD, RELOAD, ROUND_EN, ROUND_NUM, SHIFT_LEFT,
            SHIFT_AMT, LAST_ROUND, KEY_SEL, OUT_VALID};
  endfunction

  // Expected outputs c cycles after the START-accept edge.
  function automatic logic [14:0] exp_vec(input bit mode, input int unsigned c);
    int unsigned p, w, r;
    bit          dec;
    logic [1:0]  ks;
    logic [14:0] v;
    p = (c - 1) / 17;
    w = (c - 1) % 17;
    if (p >= NPASS) return HOLD_VEC;
    dec = mode ^ (p == 1);
    ks  = '0;
`ifdef DES_TRIPLE_EN
    ks = mode ? 2'(2 - p) : 2'(p);
`endif
    if (w == 0) begin
      v = {1'b0, (p == 0), (p != 0), 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, ks, 1'b0};
    end else begin
      r = w - 1;
      v = {1'b0, 1'b0, 1'b0, 1'b1, 4'(r), !dec,
           dec ? 2'(DEC_SH[r]) : 2'(ENC_SH[r]), (r == 15), ks, 1'b0};
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One block: START at the next edge, check every cycle, optional back-pressure
  // on the result (ready_delay cycles) or a reset pulse at cycle abort_at.
  task automatic run_block(input bit mode, input int unsigned ready_delay,
                           input int unsigned abort_at);
    int unsigned total;
    total = 17 * NPASS + 1;
    check("idle_pre", obs(), IDLE_VEC);
    START     = 1'b1;
    MODE      = mode;
    OUT_READY = (ready_delay == 0);
    tick();
    START = 1'b0;
    MODE  = ~mode;
    for (int unsigned c = 1; c <= total; c++) begin
      check($sformatf("m%0d_c%0d", mode, c), obs(), exp_vec(mode, c));
      if (c == abort_at) begin
        #2 RST = 1'b1;
        #1 check("async_rst", obs(), IDLE_VEC);
        tick();
        check("rst_held", obs(), IDLE_VEC);
        RST = 1'b0;
        return;
      end
      if (c != total) tick();
    end
    for (int unsigned d = 1; d < ready_delay; d++) begin
      START = 1'b1;
      tick();
      check($sformatf("hold_%0d", d), obs(), HOLD_VEC);
    end
    START     = 1'b0;
    OUT_READY = 1'b1;
    tick();
    check("done_idle", obs(), IDLE_VEC);
    tick();
    check("idle_stay", obs(), IDLE_VEC);
    OUT_READY = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    START     = 1'b0;
    MODE      = 1'b0;
    OUT_READY = 1'b0;
    #3 check("rst_init", obs(), IDLE_VEC);
    START = 1'b1;
    tick();
    tick();
    check("rst_start_ignored", obs(), IDLE_VEC);
    START = 1'b0;
    RST   = 1'b0;
    run_block(1'b0, 0, 0);
    run_block(1'b1, 0, 0);
    run_block(1'b0, 10, 0);
    run_block(1'b0, 0, 9);
    run_block(1'b1, 1, 0);
    run_block(1'b0, 3, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
